// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the EX-stage issue logic and alu_seq_exec.
// master drives requests and accepts results; slave is the execute unit.
interface alu_seq_exec_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            operation;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  illegal_op;

    modport master (
        output in_valid, operation, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal_op
    );

    modport slave (
        input  in_valid, operation, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal_op
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU for the EX stage: logic/arith/compare/branch ops plus shifts.
// Latency 1 cycle; shifts take 1+shamt unless BARREL_SHIFT_EN is defined (then 1).
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
module alu_seq_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic           clk,
    input  logic           reset,
    alu_seq_exec_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    illegal_q;
    logic [DATA_WIDTH-1:0]   calc_res;
    logic                    calc_ill;
    logic [SHAMT_WIDTH-1:0]  shamt;
    logic                    accept;
    logic                    lt_s;
    logic                    eq;

    assign shamt  = bus.src_b[SHAMT_WIDTH-1:0];
    assign accept = (state == IDLE) && bus.in_valid;
    assign lt_s   = $signed(bus.src_a) < $signed(bus.src_b);
    assign eq     = (bus.src_a == bus.src_b);

`ifndef BARREL_SHIFT_EN
    logic [3:0]             op_q;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  shift_step;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic                   is_shift;

    assign is_shift = (bus.operation == 4'b0011) || (bus.operation == 4'b0100) ||
                      (bus.operation == 4'b0110);

    always_comb begin
        case (op_q)
            4'b0011: shift_step = {shift_reg[DATA_WIDTH-2:0], 1'b0};
            4'b0100: shift_step = {1'b0, shift_reg[DATA_WIDTH-1:1]};
            default: shift_step = {shift_reg[DATA_WIDTH-1], shift_reg[DATA_WIDTH-1:1]};
        endcase
    end
`endif

    // Single-cycle result for every op; iterative shifts only use this when shamt==0.
    always_comb begin
        calc_res = '0;
        calc_ill = 1'b0;
        case (bus.operation)
            4'b0000: calc_res = bus.src_a & bus.src_b;
            4'b0001: calc_res = bus.src_a | bus.src_b;
            4'b0010: calc_res = bus.src_a + bus.src_b;
            4'b0101: calc_res = bus.src_a - bus.src_b;
            4'b1100: calc_res = bus.src_a ^ bus.src_b;
`ifdef BARREL_SHIFT_EN
            4'b0011: calc_res = bus.src_a << shamt;
            4'b0100: calc_res = bus.src_a >> shamt;
            4'b0110: calc_res = $unsigned($signed(bus.src_a) >>> shamt);
`else
            4'b0011,
            4'b0100,
            4'b0110: calc_res = bus.src_a;
`endif
            4'b1111: calc_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            4'b1000: calc_res = {{(DATA_WIDTH-1){1'b0}}, eq};
            4'b1001: calc_res = {{(DATA_WIDTH-1){1'b0}}, !eq};
            4'b1010: calc_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            4'b1011: calc_res = {{(DATA_WIDTH-1){1'b0}}, !lt_s};
            default: calc_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef BARREL_SHIFT_EN
                    state_nxt = DONE;
`else
                    state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
`endif
                end
            end
            SHIFT: begin
`ifdef BARREL_SHIFT_EN
                state_nxt = IDLE;
`else
                if (cnt == SHAMT_WIDTH'(1)) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    assign bus.result     = result_q;
    assign bus.illegal_op = illegal_q;
    assign bus.zero       = (result_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifndef BARREL_SHIFT_EN
            op_q      <= '0;
            shift_reg <= '0;
            cnt       <= '0;
`endif
        end else if (accept) begin
            result_q  <= calc_res;
            illegal_q <= calc_ill;
`ifndef BARREL_SHIFT_EN
            op_q      <= bus.operation;
            shift_reg <= bus.src_a;
            cnt       <= shamt;
        end else if (state == SHIFT) begin
            shift_reg <= shift_step;
            cnt       <= cnt - SHAMT_WIDTH'(1);
            if (cnt == SHAMT_WIDTH'(1)) begin
                result_q <= shift_step;
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed-vector bench for alu_seq_exec with a queue scoreboard and a separate output monitor.
module tb_alu_seq_exec;
    logic clk;
    logic reset;

    alu_seq_exec_if #(.DATA_WIDTH(32)) bus ();

    alu_seq_exec #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Shift latency depends on the build option.
    function automatic int shift_lat(input int n);
`ifdef BARREL_SHIFT_EN
        shift_lat = 1;
`else
        shift_lat = 1 + n;
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got result %h, expected no output", bus.result);
            end else begin
                mon_e = sb.pop_front();
                chk("result", bus.result, mon_e.res);
                chk("zero", {31'b0, bus.zero}, {31'b0, mon_e.zero});
                chk("illegal_op", {31'b0, bus.illegal_op}, {31'b0, mon_e.ill});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        int   cycles;
        exp_t e;
        e.res  = exp_res;
        e.zero = (exp_res == 32'd0);
        e.ill  = exp_ill;
        sb.push_back(e);
        wait_ready();
        bus.operation = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.src_a    = ~a;
        bus.src_b    = ~b;
        cycles = 1;
        while (!bus.out_valid && cycles < 100) begin
            chk("busy_in_ready", {31'b0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
            cycles++;
        end
        chk("latency", cycles, exp_lat);
        if (bus.out_valid) begin
            @(posedge clk); #1;
            chk("post_in_ready", {31'b0, bus.in_ready}, 32'd1);
            chk("post_out_valid", {31'b0, bus.out_valid}, 32'd0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.operation = 4'b0000;
        bus.src_a     = '0;
        bus.src_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", {31'b0, bus.zero}, 32'd1);
        chk("rst_illegal", {31'b0, bus.illegal_op}, 32'd0);
        reset = 1'b0;

        issue(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        issue(4'b0101, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
        issue(4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        issue(4'b1011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
        issue(4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1);
        issue(4'b1100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        issue(4'b1001, 32'd9, 32'd9, 32'd0, 1'b0, 1);
        issue(4'b1010, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1);
        issue(4'b0110, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, shift_lat(4));
        issue(4'b0100, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, shift_lat(1));
        issue(4'b0011, 32'd1, 32'h20, 32'd1, 1'b0, 1);
        issue(4'b0011, 32'h0000_00FF, 32'd8, 32'h0000_FF00, 1'b0, shift_lat(8));
        issue(4'b1101, 32'd3, 32'd4, 32'd0, 1'b1, 1);
        issue(4'b0111, 32'd3, 32'd4, 32'd0, 1'b1, 1);

        // Backpressure: result must hold, and requests during the stall are dropped.
        bus.out_ready = 1'b0;
        sb.push_back('{res: 32'd2, zero: 1'b0, ill: 1'b0});
        wait_ready();
        bus.operation = 4'b0010;
        bus.src_a     = 32'd1;
        bus.src_b     = 32'd1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.src_a    = 32'd9;
            bus.src_b    = 32'd9;
            chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_result", bus.result, 32'd2);
            chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_no_latched_req", {31'b0, bus.out_valid}, 32'd0);

        // Reset while a long shift is in flight.
`ifdef BARREL_SHIFT_EN
        issue(4'b0011, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
`else
        wait_ready();
        bus.operation = 4'b0011;
        bus.src_a     = 32'd1;
        bus.src_b     = 32'd31;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("mid_shift_busy", {31'b0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
`endif
        chk("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("abort_zero", {31'b0, bus.zero}, 32'd1);
        reset = 1'b0;

        issue(4'b1000, 32'd9, 32'd9, 32'd1, 1'b0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule
